aes_round_key_sequencer: RTL and testbench



---
 rtl/aes_round_key_sequencer_pkg.sv | 51 +++++
 rtl/aes_round_key_sequencer_if.sv | 24 ++
 rtl/aes_round_key_sequencer_key_step.sv | 44 ++++
 rtl/aes_round_key_sequencer.sv | 115 +++++++++++
 tb/tb_aes_round_key_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_round_key_sequencer_pkg.sv
// Shared AES-128 key-schedule definitions: round count, sequencer states,
// the Rcon table and the byte S-box used by the key-step datapath.
package aes_pkg;

  localparam int unsigned NR_AES128 = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRE    = 2'd1,
    ST_STREAM = 2'd2
  } seq_state_e;

  // Round constant for round 1..10; anything else contributes nothing.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_round_key_sequencer_if.sv
// Key-load and round-key stream signals of the sequencer. master is the
// sequencer side, slave is the key source / round datapath side.
interface aes_round_key_sequencer_if;
  logic [127:0] i_Key;
  logic         i_KeyValid;
  logic         o_KeyReady;
  logic         i_fDec;
  logic [127:0] o_RoundKey;
  logic [3:0]   o_RoundIdx;
  logic         o_RkValid;
  logic         i_RkReady;
  logic         o_Busy;
  logic         o_Done;

  modport master (
    input  i_Key, i_KeyValid, i_fDec, i_RkReady,
    output o_KeyReady, o_RoundKey, o_RoundIdx, o_RkValid, o_Busy, o_Done
  );

  modport slave (
    output i_Key, i_KeyValid, i_fDec, i_RkReady,
    input  o_KeyReady, o_RoundKey, o_RoundIdx, o_RkValid, o_Busy, o_Done
  );
endinterface

// File: rtl/aes_round_key_sequencer_key_step.sv
// One AES-128 key-schedule step, forward (to round i_Rnd) or inverse (from
// round i_Rnd). Purely combinational; four byte S-boxes.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_Key,
  input  logic [3:0]   i_Rnd,
  input  logic         i_fInv,
  output logic [127:0] o_Key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] inv_w1, inv_w2, inv_w3;
  logic [31:0] sb_in, rot_word, sub_word, t_word;
  logic [31:0] fwd_w0, fwd_w1, fwd_w2, fwd_w3;

  assign {w0, w1, w2, w3} = i_Key;

  assign inv_w3 = w3 ^ w2;
  assign inv_w2 = w2 ^ w1;
  assign inv_w1 = w1 ^ w0;

  // The inverse step needs the recovered previous w3 as S-box input.
  assign sb_in    = i_fInv ? inv_w3 : w3;
  assign rot_word = {sb_in[23:0], sb_in[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_word[gi*8 +: 8] = SBOX[rot_word[gi*8 +: 8]];
    end
  endgenerate

  assign t_word = sub_word ^ {rcon(i_Rnd), 24'h000000};

  assign fwd_w0 = w0 ^ t_word;
  assign fwd_w1 = w1 ^ fwd_w0;
  assign fwd_w2 = w2 ^ fwd_w1;
  assign fwd_w3 = w3 ^ fwd_w2;

  assign o_Key = i_fInv ? {w0 ^ t_word, inv_w1, inv_w2, inv_w3}
                        : {fwd_w0, fwd_w1, fwd_w2, fwd_w3};

endmodule

// File: rtl/aes_round_key_sequencer.sv
// AES-128 round-key sequencer: loads a key and streams rk0..rk10 (encrypt)
// or rk10..rk0 (decrypt, optionally after a forward pre-pass).
module aes_round_key_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NR         = 10,
  parameter bit          DEC_KEY_IN = 1'b0
)
(
  input  logic                            i_Clk,
  input  logic                            i_Rst,
  aes_round_key_sequencer_if.master       bus
);

  generate
    if (NR != NR_AES128) begin : g_nr_check
      $fatal(1, "aes_round_key_sequencer: only NR=10 (AES-128) is supported");
    end
  endgenerate

  localparam logic [3:0] LAST_IDX = 4'(NR);

  seq_state_e   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic         dec_q, dec_d;
  logic         done_q, done_d;

  logic [3:0]   step_rnd;
  logic         step_inv;
  logic [127:0] step_key;

  // Forward steps are tagged with the destination round, inverse with the source.
  assign step_inv = (state_q == ST_STREAM) && dec_q;
  assign step_rnd = step_inv ? idx_q : idx_q + 4'd1;

  aes_key_step u_key_step (
    .i_Key  (key_q),
    .i_Rnd  (step_rnd),
    .i_fInv (step_inv),
    .o_Key  (step_key)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_KeyValid) begin
          key_d = bus.i_Key;
          dec_d = bus.i_fDec;
          if (!bus.i_fDec) begin
            state_d = ST_STREAM;
            idx_d   = 4'd0;
          end else if (DEC_KEY_IN) begin
            state_d = ST_STREAM;
            idx_d   = LAST_IDX;
          end else begin
            state_d = ST_PRE;
            idx_d   = 4'd0;
          end
        end
      end
      ST_PRE: begin
        key_d = step_key;
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_IDX - 4'd1) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (bus.i_RkReady) begin
          // Last key leaves the key register and index untouched.
          if ((dec_q && idx_q == 4'd0) || (!dec_q && idx_q == LAST_IDX)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = step_key;
            idx_d = dec_q ? idx_q - 4'd1 : idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_KeyReady = (state_q == ST_IDLE);
  assign bus.o_Busy     = (state_q != ST_IDLE);
  assign bus.o_RkValid  = (state_q == ST_STREAM);
  assign bus.o_RoundKey = (state_q == ST_STREAM) ? key_q : '0;
  assign bus.o_RoundIdx = (state_q == ST_STREAM) ? idx_q : '0;
  assign bus.o_Done     = done_q;

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Bench for aes_round_key_sequencer: two instances (DEC_KEY_IN=0/1) checked
// against a FIPS-197 style key expansion computed with GF(2^8) arithmetic.
module tb_aes_round_key_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_round_key_sequencer_if if0 ();
  aes_round_key_sequencer_if if1 ();

  aes_round_key_sequencer #(.NR(10), .DEC_KEY_IN(1'b0)) dut0 (
    .i_Clk (clk), .i_Rst (rst), .bus (if0.master)
  );
  aes_round_key_sequencer #(.NR(10), .DEC_KEY_IN(1'b1)) dut1 (
    .i_Clk (clk), .i_Rst (rst), .bus (if1.master)
  );

  logic         tsel = 1'b0;
  logic [127:0] key_drv = '0;
  logic         kv_drv = 1'b0, dec_drv = 1'b0, rdy_drv = 1'b0;

  assign if0.i_Key      = key_drv;
  assign if1.i_Key      = key_drv;
  assign if0.i_fDec     = dec_drv;
  assign if1.i_fDec     = dec_drv;
  assign if0.i_KeyValid = kv_drv & ~tsel;
  assign if1.i_KeyValid = kv_drv & tsel;
  assign if0.i_RkReady  = rdy_drv & ~tsel;
  assign if1.i_RkReady  = rdy_drv & tsel;

  logic [127:0] o_rk;
  logic [3:0]   o_idx;
  logic         o_valid, o_kready, o_busy, o_done;
  assign o_rk     = tsel ? if1.o_RoundKey : if0.o_RoundKey;
  assign o_idx    = tsel ? if1.o_RoundIdx : if0.o_RoundIdx;
  assign o_valid  = tsel ? if1.o_RkValid  : if0.o_RkValid;
  assign o_kready = tsel ? if1.o_KeyReady : if0.o_KeyReady;
  assign o_busy   = tsel ? if1.o_Busy     : if0.o_Busy;
  assign o_done   = tsel ? if1.o_Done     : if0.o_Done;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [127:0] ref_rk  [0:10];
  logic [127:0] exp_key [0:10];
  logic [3:0]   exp_idx [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic compute_ref(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic fill_exp(input bit dec);
    for (int n = 0; n < 11; n++) begin
      exp_key[n] = dec ? ref_rk[10-n] : ref_rk[n];
      exp_idx[n] = dec ? 4'(10-n) : 4'(n);
    end
  endtask

  task automatic run_key(input bit s, input logic [127:0] k, input bit d,
                         input int pct, input bit intrude, input int exp_lat, input string name);
    int lat, n, cyc;
    @(negedge clk);
    tsel = s; key_drv = k; dec_drv = d; kv_drv = 1'b1; rdy_drv = 1'b0;
    check({name, "_kready_idle"}, 128'(o_kready), 128'(1));
    @(posedge clk); #1;
    kv_drv = 1'b0; key_drv = {$urandom, $urandom, $urandom, $urandom}; dec_drv = 1'($urandom);
    check({name, "_done_clear"}, 128'(o_done), 128'(0));
    check({name, "_busy"}, 128'(o_busy), 128'(1));
    lat = 1;
    while (!o_valid && lat < 30) begin
      check({name, "_pre_kready"}, 128'(o_kready), 128'(0));
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 128'(lat), 128'(exp_lat));
    n = 0; cyc = 0;
    while (n < 11 && cyc < 500) begin
      check({name, "_valid"}, 128'(o_valid), 128'(1));
      check({name, "_rk"}, o_rk, exp_key[n]);
      check({name, "_idx"}, 128'(o_idx), 128'(exp_idx[n]));
      check({name, "_kready_busy"}, 128'(o_kready), 128'(0));
      rdy_drv = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      if (intrude && cyc == 3) begin
        kv_drv = 1'b1; key_drv = ~k; dec_drv = ~d;
      end
      @(posedge clk); #1;
      kv_drv = 1'b0;
      if (rdy_drv) n++;
      cyc++;
    end
    rdy_drv = 1'b0;
    check({name, "_count"}, 128'(n), 128'(11));
    check({name, "_done"}, 128'(o_done), 128'(1));
    check({name, "_valid_end"}, 128'(o_valid), 128'(0));
    check({name, "_kready_end"}, 128'(o_kready), 128'(1));
    $display("txn %s sel=%0d dec=%0d latency=%0d cycles=%0d keys=%0d", name, s, d, lat, cyc, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rk;
    bit           rd, rs, ri;
    // Reset state
    #2;
    for (int s = 0; s < 2; s++) begin
      tsel = 1'(s); #1;
      check("rst_kready", 128'(o_kready), 128'(1));
      check("rst_busy",   128'(o_busy),   128'(0));
      check("rst_valid",  128'(o_valid),  128'(0));
      check("rst_done",   128'(o_done),   128'(0));
      check("rst_rk",     o_rk,           128'(0));
      check("rst_idx",    128'(o_idx),    128'(0));
    end
    @(negedge clk); rst = 1'b0;

    // 1: encrypt known vector, full throughput
    compute_ref(FIPS_KEY);
    ref_rk[1] = FIPS_RK1;
    ref_rk[10] = FIPS_RK10;
    fill_exp(1'b0);
    run_key(1'b0, FIPS_KEY, 1'b0, 100, 1'b0, 1, "enc_fips");

    // 2: decrypt with forward pre-pass
    fill_exp(1'b1);
    run_key(1'b0, FIPS_KEY, 1'b1, 100, 1'b0, 11, "dec_pre");

    // 3: decrypt with the last round key supplied directly
    run_key(1'b1, FIPS_RK10, 1'b1, 100, 1'b0, 1, "dec_direct");

    // 4: backpressure
    fill_exp(1'b0);
    run_key(1'b0, FIPS_KEY, 1'b0, 50, 1'b0, 1, "enc_bp");

    // 5: key offered mid-stream must be ignored
    fill_exp(1'b1);
    run_key(1'b0, FIPS_KEY, 1'b1, 60, 1'b1, 11, "dec_intrude");

    // 6: reset in the 4th PRE cycle
    @(negedge clk);
    tsel = 1'b0; key_drv = FIPS_KEY; dec_drv = 1'b1; kv_drv = 1'b1;
    @(posedge clk); #1;
    kv_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_valid", 128'(o_valid), 128'(0));
    check("pre_busy",  128'(o_busy),  128'(1));
    #1 rst = 1'b1;
    #1;
    check("arst_kready", 128'(o_kready), 128'(1));
    check("arst_busy",   128'(o_busy),   128'(0));
    check("arst_valid",  128'(o_valid),  128'(0));
    check("arst_done",   128'(o_done),   128'(0));
    check("arst_rk",     o_rk,           128'(0));
    $display("txn reset_mid_pre kready=%0d busy=%0d", o_kready, o_busy);
    @(negedge clk); rst = 1'b0;
    rk = {$urandom, $urandom, $urandom, $urandom};
    compute_ref(rk);
    fill_exp(1'b0);
    run_key(1'b0, rk, 1'b0, 100, 1'b0, 1, "enc_after_rst");

    // Randomized keys, modes, instances and backpressure
    for (int it = 0; it < 10; it++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rd = 1'($urandom);
      rs = 1'($urandom);
      ri = 1'($urandom);
      compute_ref(rk);
      fill_exp(rd);
      if (rs && rd)
        run_key(rs, ref_rk[10], rd, 30 + $urandom_range(0, 70), ri, 1, "rand");
      else
        run_key(rs, rk, rd, 30 + $urandom_range(0, 70), ri, rd ? 11 : 1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
